// File: rtl/dgn_dtw_min_tracker.sv
// dgn_dtw_min_tracker: running minimum and first index of a DTW cost stream per query pass.
// Optional threshold-hit flag when DGN_TRACK_HIT_EN is defined.
module dgn_dtw_min_tracker #(
    parameter int width     = 18,
    parameter int idx_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cost_valid,
    input  logic [width-1:0]     cost,
    input  logic                 cost_last,
    input  logic [width-1:0]     thresh,
    output logic                 busy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [width-1:0]     res_min,
    output logic [idx_width-1:0] res_idx,
    output logic                 res_hit,
    output logic                 res_ovf
);
    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;
    state_t state, state_nxt;
    // One extra bit lets the counter tell "2^idx_width beats seen" apart from "more than that".
    logic [idx_width:0] cnt;
    logic init, beat, upd;
    assign init = start && (state != HOLD || res_ready);
    assign beat = state == TRACK && cost_valid && !start;
    assign upd  = beat && cost < res_min;
    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end
    // Next state: a (re)start wins over everything, then drain, then end of pass.
    always_comb begin
        state_nxt = state;
        if (init) state_nxt = TRACK;
        else if (state == HOLD && res_ready) state_nxt = IDLE;
        else if (beat && cost_last) state_nxt = HOLD;
    end
    // Status outputs decoded from state.
    always_comb begin
        busy      = state == TRACK;
        res_valid = state == HOLD;
    end
    // Running minimum, first index (saturated) and overflow; these are also the result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || init) begin
            res_min <= '1;
            res_idx <= '0;
            cnt     <= '0;
            res_ovf <= 1'b0;
        end else if (beat) begin
            if (upd) begin
                res_min <= cost;
                res_idx <= cnt[idx_width] ? '1 : cnt[idx_width-1:0];
            end
            if (cnt[idx_width]) res_ovf <= 1'b1;
            else cnt <= cnt + 1'b1;
        end
    end
`ifdef DGN_TRACK_HIT_EN
    logic [width-1:0] min_nxt;
    assign min_nxt = upd ? cost : res_min;
    // Threshold hit evaluated on the final beat against the updated minimum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || init) res_hit <= 1'b0;
        else if (beat && cost_last) res_hit <= min_nxt <= thresh;
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign res_hit = 1'b0;
`endif
endmodule
